mmio_bridge: RTL and testbench

Memory-mapped data bus bridge between the pipelined CPU's MEM-stage data port and the SWORD board resources. Decodes the CPU's data address into on-chip data RAM and a small peripheral register file (LED, 7-segment, switches/buttons, timer), applies byte write enables and returns read data to the CPU. It also provides a prescaled 32-bit timer with a compare-match interrupt output.

---
 rtl/mmio_bridge.sv | 153 +++++++++++++++
 tb/tb_mmio_bridge.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU data-port decoder for on-chip data RAM and the board
// peripheral registers (LED, 7-segment, switches/buttons), plus a prescaled
// 32-bit timer with a compare-match interrupt.
module mmio_bridge #(
    parameter int unsigned PRESC  = 50,
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_w,
    input  logic [3:0]        wea,
    input  logic [31:0]       Addr_out,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw,
    input  logic [4:0]        btn,
    output logic [31:0]       led,
    output logic [31:0]       seg,
    output logic              irq
);

    // Register word addresses (byte address >> 2)
    localparam logic [29:0] SEG_W  = 30'h3800_0000;
    localparam logic [29:0] LED_W  = 30'h3C00_0000;
    localparam logic [29:0] INP_W  = 30'h3C00_0001;
    localparam logic [29:0] CNT_W  = 30'h3C00_0004;
    localparam logic [29:0] CMP_W  = 30'h3C00_0005;
    localparam logic [29:0] CTRL_W = 30'h3C00_0006;
    localparam logic [29:0] STAT_W = 30'h3C00_0007;

    localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

    logic [29:0]   wa;
    logic          is_ram;
    logic          wr_led, wr_seg, wr_cnt, wr_cmp, wr_ctrl, wr_stat;
    logic [31:0]   cnt, cmp, cnt_tick, cnt_next;
    logic [2:0]    ctrl;
    logic          match;
    logic [PW-1:0] pcnt;
    logic          tick, hit, en_rise;
    logic [15:0]   sw_m, sw_s;
    logic [4:0]    btn_m, btn_s;

    // Byte offset bits take no part in register selection
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, Addr_out[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    assign wa       = Addr_out[31:2];
    assign is_ram   = (Addr_out[31:12] == '0);
    assign wr_led   = mem_w && (wa == LED_W);
    assign wr_seg   = mem_w && (wa == SEG_W);
    assign wr_cnt   = mem_w && (wa == CNT_W);
    assign wr_cmp   = mem_w && (wa == CMP_W);
    assign wr_ctrl  = mem_w && (wa == CTRL_W) && wea[0];
    assign wr_stat  = mem_w && (wa == STAT_W) && wea[0];

    assign ram_addr = Addr_out[RAM_AW+1:2];
    assign ram_we   = (mem_w && is_ram) ? wea : '0;
    assign ram_din  = Data_out;

    assign tick     = ctrl[0] && (pcnt == PLAST);
    assign hit      = (cnt == cmp);
    assign en_rise  = wr_ctrl && Data_out[0] && !ctrl[0];
    assign irq      = match & ctrl[2];

    // Tick result first, then CPU-written bytes override it lane by lane
    always_comb begin
        cnt_tick = cnt;
        if (tick) cnt_tick = (hit && ctrl[1]) ? '0 : cnt + 32'd1;
        cnt_next = wr_cnt ? merge(cnt_tick, Data_out, wea) : cnt_tick;
    end

    // Read-data multiplexer, zero latency
    always_comb begin
        Data_in = '0;
        if (is_ram) begin
            Data_in = ram_dout;
        end else begin
            case (wa)
                SEG_W:   Data_in = seg;
                LED_W:   Data_in = led;
                INP_W:   Data_in = {11'b0, btn_s, sw_s};
                CNT_W:   Data_in = cnt;
                CMP_W:   Data_in = cmp;
                CTRL_W:  Data_in = {29'b0, ctrl};
                STAT_W:  Data_in = {31'b0, match};
                default: Data_in = '0;
            endcase
        end
    end

    // Two-flop synchronisers for the board inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {btn_m, sw_m} <= '0;
            {btn_s, sw_s} <= '0;
        end else begin
            {btn_m, sw_m} <= {btn, sw};
            {btn_s, sw_s} <= {btn_m, sw_m};
        end
    end

    // Byte-writable LED and 7-segment registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
            seg <= '0;
        end else begin
            if (wr_led) led <= merge(led, Data_out, wea);
            if (wr_seg) seg <= merge(seg, Data_out, wea);
        end
    end

    // Timer state: prescaler, counter, compare, control and match flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            cnt   <= '0;
            cmp   <= '1;
            ctrl  <= '0;
            match <= 1'b0;
        end else begin
            if (en_rise)
                pcnt <= '0;
            else if (ctrl[0])
                pcnt <= tick ? '0 : pcnt + PW'(1);
            cnt <= cnt_next;
            if (wr_cmp)  cmp  <= merge(cmp, Data_out, wea);
            if (wr_ctrl) ctrl <= Data_out[2:0];
            // A match set in the same cycle as a clear takes priority
            if (tick && hit)
                match <= 1'b1;
            else if (wr_stat && Data_out[0])
                match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed stimulus with a behavioural model of the register
// map and timer, compared on every falling clock edge, plus literal checks.
module tb_mmio_bridge;

    localparam int P = 4;

    localparam logic [31:0] A_SEG  = 32'hE000_0000;
    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_INP  = 32'hF000_0004;
    localparam logic [31:0] A_CNT  = 32'hF000_0010;
    localparam logic [31:0] A_CMP  = 32'hF000_0014;
    localparam logic [31:0] A_CTRL = 32'hF000_0018;
    localparam logic [31:0] A_STAT = 32'hF000_001C;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_w;
    logic [3:0]  wea;
    logic [31:0] Addr_out, Data_out, Data_in, ram_din, ram_dout, led, seg;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_we;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    mmio_bridge #(.PRESC(P), .RAM_AW(10)) dut (
        .clk(clk), .rst(rst), .mem_w(mem_w), .wea(wea),
        .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .sw(sw), .btn(btn),
        .led(led), .seg(seg), .irq(irq)
    );

    always #5 clk = ~clk;

    assign ram_dout = Addr_out ^ 32'h5A5A_5A5A;

    // ---------------- behavioural model ----------------
    logic [31:0] m_led, m_seg, m_cnt, m_cmp;
    logic [2:0]  m_ctrl;
    logic        m_match;
    int          m_pcnt;
    logic [20:0] m_in1, m_in2;

    function automatic logic [31:0] lanes(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a < 32'h0000_1000) return a ^ 32'h5A5A_5A5A;
        case (w)
            A_SEG:   return m_seg;
            A_LED:   return m_led;
            A_INP:   return {11'b0, m_in2};
            A_CNT:   return m_cnt;
            A_CMP:   return m_cmp;
            A_CTRL:  return {29'b0, m_ctrl};
            A_STAT:  return {31'b0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] w, nc;
        logic        tk, ht, nm;
        int          np;
        if (rst) begin
            m_led <= 0; m_seg <= 0; m_cnt <= 0; m_cmp <= 32'hFFFF_FFFF;
            m_ctrl <= 0; m_match <= 0; m_pcnt <= 0; m_in1 <= 0; m_in2 <= 0;
        end else begin
            w  = {Addr_out[31:2], 2'b00};
            tk = m_ctrl[0] && (m_pcnt == P - 1);
            ht = (m_cnt == m_cmp);
            nc = m_cnt;
            nm = m_match;
            np = m_pcnt;
            if (m_ctrl[0]) np = tk ? 0 : m_pcnt + 1;
            if (tk) begin
                if (ht) begin
                    nm = 1'b1;
                    nc = m_ctrl[1] ? 32'h0 : m_cnt + 32'h1;
                end else begin
                    nc = m_cnt + 32'h1;
                end
            end
            if (mem_w) begin
                case (w)
                    A_LED: m_led <= lanes(m_led, Data_out, wea);
                    A_SEG: m_seg <= lanes(m_seg, Data_out, wea);
                    A_CNT: nc = lanes(nc, Data_out, wea);
                    A_CMP: m_cmp <= lanes(m_cmp, Data_out, wea);
                    A_CTRL: if (wea[0]) begin
                        if (Data_out[0] && !m_ctrl[0]) np = 0;
                        m_ctrl <= Data_out[2:0];
                    end
                    A_STAT: if (wea[0] && Data_out[0]) nm = tk && ht;
                    default: ;
                endcase
            end
            m_cnt   <= nc;
            m_match <= nm;
            m_pcnt  <= np;
            m_in2   <= m_in1;
            m_in1   <= {btn, sw};
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("Data_in", Data_in, m_read(Addr_out));
        check("ram_we", {28'b0, ram_we},
              (mem_w && Addr_out < 32'h1000) ? {28'b0, wea} : 32'h0);
        check("ram_addr", {22'b0, ram_addr}, {22'b0, Addr_out[11:2]});
        check("ram_din", ram_din, Data_out);
        check("led", led, m_led);
        check("seg", seg, m_seg);
        check("irq", {31'b0, irq}, {31'b0, m_match & m_ctrl[2]});
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        Addr_out = a; Data_out = d; wea = be; mem_w = 1'b1;
        cyc();
        mem_w = 1'b0; wea = 4'b0; Data_out = 32'h0;
    endtask

    task automatic peek(input logic [31:0] a);
        Addr_out = a; mem_w = 1'b0;
        #1;
    endtask

    initial begin : watchdog
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; mem_w = 1'b0; wea = 4'b0; Addr_out = 32'h0;
        Data_out = 32'h0; sw = 16'h0; btn = 5'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        peek(A_CMP);  check("cmp_rst", Data_in, 32'hFFFF_FFFF);
        peek(A_CNT);  check("cnt_rst", Data_in, 32'h0);
        check("led_rst", led, 32'h0);
        check("irq_rst", {31'b0, irq}, 32'h0);
        cyc();

        // RAM byte store
        Addr_out = 32'h0000_0104; Data_out = 32'h00AB_0000; wea = 4'b0100; mem_w = 1'b1;
        #1;
        check("ram_addr_lit", {22'b0, ram_addr}, 32'h41);
        check("ram_we_lit", {28'b0, ram_we}, 32'h4);
        cyc();
        // Store to LED does not touch RAM
        Addr_out = A_LED; Data_out = 32'h1234_5678; wea = 4'hF; mem_w = 1'b1;
        #1;
        check("ram_we_io", {28'b0, ram_we}, 32'h0);
        cyc();
        mem_w = 1'b0; wea = 4'b0;

        // LED partial write, unmapped read/write, SEG lanes, wea=0 write
        wr(A_LED, 32'hFFFF_FFFF, 4'b0011);
        peek(A_LED);
        check("led_part", led, 32'h1234_FFFF);
        check("led_rdbk", Data_in, 32'h1234_FFFF);
        peek(32'hF000_0020); check("unmapped_rd", Data_in, 32'h0);
        wr(32'hF000_0020, 32'hDEAD_BEEF, 4'hF);
        wr(A_SEG, 32'hCAFE_BABE, 4'b1010);
        check("seg_part", seg, 32'hCA00_BA00);
        wr(A_LED, 32'h0, 4'b0000);
        check("led_wea0", led, 32'h1234_FFFF);

        // Input synchroniser latency
        sw = 16'hA5A5; btn = 5'b10001; Addr_out = A_INP;
        #1 check("inp_0clk", Data_in, 32'h0);
        cyc(); check("inp_1clk", Data_in, 32'h0);
        cyc(); check("inp_2clk", Data_in, 32'h0011_A5A5);

        // Timer with autoreload
        wr(A_CMP, 32'h3, 4'hF);
        wr(A_CTRL, 32'h7, 4'b0001);
        Addr_out = A_CNT;
        repeat (3) cyc();
        check("cnt_e3", Data_in, 32'h0);
        cyc();
        check("cnt_e4", Data_in, 32'h1);
        repeat (11) cyc();
        check("cnt_e15", Data_in, 32'h3);
        check("irq_e15", {31'b0, irq}, 32'h0);
        cyc();
        check("cnt_reload", Data_in, 32'h0);
        check("irq_match", {31'b0, irq}, 32'h1);
        wr(A_STAT, 32'h1, 4'b0001);
        check("irq_clr", {31'b0, irq}, 32'h0);

        // Timer without autoreload
        wr(A_CTRL, 32'h0, 4'b0001);
        wr(A_CNT, 32'h3, 4'hF);
        wr(A_CTRL, 32'h5, 4'b0001);
        Addr_out = A_CNT;
        repeat (3) cyc();
        check("cnt_hold3", Data_in, 32'h3);
        cyc();
        check("cnt_noreload", Data_in, 32'h4);
        check("irq_noreload", {31'b0, irq}, 32'h1);

        // CNT write colliding with a tick
        wr(A_CTRL, 32'h0, 4'b0001);
        wr(A_STAT, 32'h1, 4'b0001);
        wr(A_CMP, 32'hFFFF_FFFF, 4'hF);
        wr(A_CNT, 32'h105, 4'hF);
        wr(A_CTRL, 32'h1, 4'b0001);
        repeat (3) cyc();
        wr(A_CNT, 32'h10, 4'b0001);
        peek(A_CNT); check("cnt_collide", Data_in, 32'h0000_0110);
        repeat (4) cyc();
        check("cnt_after", Data_in, 32'h0000_0111);

        // STAT clear colliding with a match tick
        wr(A_CTRL, 32'h0, 4'b0001);
        wr(A_CMP, 32'h5, 4'hF);
        wr(A_CNT, 32'h5, 4'hF);
        wr(A_CTRL, 32'h5, 4'b0001);
        repeat (3) cyc();
        wr(A_STAT, 32'h1, 4'b0001);
        peek(A_STAT); check("stat_collide", Data_in, 32'h1);
        check("irq_collide", {31'b0, irq}, 32'h1);
        peek(A_CNT); check("cnt_match6", Data_in, 32'h6);

        // Asynchronous reset between edges
        cyc();
        #1 rst = 1'b1;
        #1;
        check("led_arst", led, 32'h0);
        check("seg_arst", seg, 32'h0);
        check("irq_arst", {31'b0, irq}, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        peek(A_CMP); check("cmp_arst", Data_in, 32'hFFFF_FFFF);
        peek(A_CNT); check("cnt_arst", Data_in, 32'h0);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
